// File: rtl/divisor_sequencial.sv
// Sequential 4-bit unsigned restoring divider, one quotient bit per clock.
// Every trial subtraction goes through a single 4-bit ripple-borrow subtractor.

module subtrator (
    output logic [3:0] S,
    output logic       Bout,
    input  logic [3:0] A,
    input  logic [3:0] B
);

    logic [4:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_cell
        assign S[i]          = A[i] ^ B[i] ^ borrow[i];
        assign borrow[i + 1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow[i]);
    end

    assign Bout = borrow[4];

endmodule

module divisor_sequencial (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] dividendo,
    input  logic [3:0] divisor,
    output logic [3:0] quociente,
    output logic [3:0] resto,
    output logic       ocupado,
    output logic       pronto,
    output logic       erro_div0
);

    typedef enum logic [1:0] {
        OCIOSO,
        CALC,
        FIM
    } estado_t;

    estado_t    estado;
    logic [3:0] r;
    logic [3:0] q;
    logic [3:0] d;
    logic [1:0] contador;

    logic [3:0] t;
    logic [3:0] s;
    logic       bout;
    logic [3:0] r_prox;
    logic [3:0] q_prox;

    // r stays below d (at most 7), so shifting in the next dividend bit fits in 4 bits
    assign t = {r[2:0], q[3]};

    subtrator u_sub (
        .S    (s),
        .Bout (bout),
        .A    (t),
        .B    (d)
    );

    // A borrow means the trial subtraction failed: restore t and shift in a 0
    always_comb begin
        r_prox = bout ? t : s;
        q_prox = {q[2:0], ~bout};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= OCIOSO;
            r         <= '0;
            q         <= '0;
            d         <= '0;
            contador  <= '0;
            quociente <= '0;
            resto     <= '0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
            erro_div0 <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        d        <= divisor;
                        q        <= dividendo;
                        r        <= '0;
                        contador <= 2'd3;
                        if (divisor != 4'd0) begin
                            estado  <= CALC;
                            ocupado <= 1'b1;
                        end else begin
                            estado    <= FIM;
                            quociente <= 4'hF;
                            resto     <= dividendo;
                            erro_div0 <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r        <= r_prox;
                    q        <= q_prox;
                    contador <= contador - 2'd1;
                    if (contador == 2'd0) begin
                        estado    <= FIM;
                        ocupado   <= 1'b0;
                        quociente <= q_prox;
                        resto     <= r_prox;
                        erro_div0 <= 1'b0;
                    end
                end
                FIM: begin
                    pronto <= 1'b1;
                    estado <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule
